// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default width.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int unsigned DIV_WIDTH = 32;

endpackage

// File: rtl/seq_divider_prefix_subtractor.sv
// Kogge-Stone prefix subtractor: diff = a + ~b + 1, cout=1 means no borrow.
module prefix_subtractor #(
    parameter int unsigned N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         cout
);

    localparam int unsigned LEVELS = $clog2(N);

    logic [N-1:0] w_p0;
    logic [N-1:0] w_g;
    logic [N-1:0] w_p;
    logic [N-1:0] w_gn;
    logic [N-1:0] w_pn;
    logic [N-1:0] w_carry;

    always_comb begin
        w_p0 = a ^ ~b;
        w_g  = a & ~b;
        // Carry-in of 1 is absorbed into bit 0: g0 = g0 | p0.
        w_g[0] = w_g[0] | w_p0[0];
        w_p  = w_p0;
        w_gn = '0;
        w_pn = '0;
        for (int unsigned l = 0; l < LEVELS; l++) begin
            w_gn = w_g;
            w_pn = w_p;
            for (int unsigned i = 0; i < N; i++) begin
                if (i >= (32'd1 << l)) begin
                    w_gn[i] = w_g[i] | (w_p[i] & w_g[i - (32'd1 << l)]);
                    w_pn[i] = w_p[i] & w_p[i - (32'd1 << l)];
                end
            end
            w_g = w_gn;
            w_p = w_pn;
        end
        w_carry = {w_g[N-2:0], 1'b1};
        diff    = w_p0 ^ w_carry;
        cout    = w_g[N-1];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;
    logic [WIDTH-1:0]   r_div;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic               r_dbz;

    logic [WIDTH:0]     w_t;
    logic [WIDTH:0]     w_diff;
    logic               w_cout;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_r_next;
    logic [WIDTH-1:0]   w_q_next;

    assign w_t = {r_r, r_q[WIDTH-1]};

    prefix_subtractor #(.N(WIDTH + 1)) u_sub (
        .a    (w_t),
        .b    ({1'b0, r_div}),
        .diff (w_diff),
        .cout (w_cout)
    );

    // With R < divisor the difference MSB is always 0 when there is no borrow.
    assign w_qbit   = w_cout & ~w_diff[WIDTH];
    assign w_r_next = w_qbit ? w_diff[WIDTH-1:0] : w_t[WIDTH-1:0];
    assign w_q_next = {r_q[WIDTH-2:0], w_qbit};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_state_next = (divisor == '0) ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (r_cnt == '0) w_state_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_q    <= '0;
            r_r    <= '0;
            r_div  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (divisor != '0) begin
                            r_div <= divisor;
                            r_q   <= dividend;
                            r_r   <= '0;
                            r_cnt <= CNT_W'(WIDTH - 1);
                        end else begin
                            r_quot <= '1;
                            r_rem  <= dividend;
                            r_dbz  <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_q <= w_q_next;
                    r_r <= w_r_next;
                    if (r_cnt == '0) begin
                        r_quot <= w_q_next;
                        r_rem  <= w_r_next;
                        r_dbz  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule
